// File: rtl/ps2_scancode_rx_pkg.sv
// Shared definitions for the PS/2 scan-code receiver: prefix bytes, frame FSM
// encoding, keyboard scan-code constants and the frame parity helper.
package ps2_scancode_rx_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Scan-code set 2 keys shared with the kb2piano mapping stage
    localparam logic [7:0] KB_A  = 8'h1C;
    localparam logic [7:0] KB_S  = 8'h1B;
    localparam logic [7:0] KB_D  = 8'h23;
    localparam logic [7:0] KB_Z  = 8'h1A;
    localparam logic [7:0] KB_X  = 8'h22;
    localparam logic [7:0] KB_UP = 8'h75;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_scancode_rx_if.sv
// Pin and key-event bundle between the PS/2 receiver and the key-mapping stage.
interface ps2_scancode_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       new_key;
    logic       key_released;
    logic [7:0] key_code;
    logic       key_extended;
    logic       frame_err;

    modport master (
        input  ps2_clk, ps2_data,
        output new_key, key_released, key_code, key_extended, frame_err
    );

    modport slave (
        output ps2_clk, ps2_data,
        input  new_key, key_released, key_code, key_extended, frame_err
    );
endinterface

// File: rtl/ps2_line_filter.sv
// Synchronises and debounces the PS/2 clock/data pin pair and produces a
// one-cycle strobe on each falling edge of the filtered clock.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic filt_clk,
    output logic filt_data,
    output logic fall
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [1:0]    clk_sync_r;
    logic [1:0]    data_sync_r;
    logic [CW-1:0] clk_cnt_r;
    logic [CW-1:0] data_cnt_r;
    logic          filt_clk_r;
    logic          filt_data_r;
    logic          fall_r;

    // Two-flop synchronisers; the idle bus level is high
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_r  <= 2'b11;
            data_sync_r <= 2'b11;
        end else begin
            clk_sync_r  <= {clk_sync_r[0], ps2_clk};
            data_sync_r <= {data_sync_r[0], ps2_data};
        end
    end

    // Clock stability filter and fall strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_clk_r <= 1'b1;
            clk_cnt_r  <= '0;
            fall_r     <= 1'b0;
        end else begin
            fall_r <= 1'b0;
            if (clk_sync_r[1] == filt_clk_r) begin
                clk_cnt_r <= '0;
            end else if (clk_cnt_r == CNT_LAST) begin
                filt_clk_r <= clk_sync_r[1];
                clk_cnt_r  <= '0;
                fall_r     <= filt_clk_r & ~clk_sync_r[1];
            end else begin
                clk_cnt_r <= clk_cnt_r + CW'(1);
            end
        end
    end

    // Data stability filter
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_data_r <= 1'b1;
            data_cnt_r  <= '0;
        end else if (data_sync_r[1] == filt_data_r) begin
            data_cnt_r <= '0;
        end else if (data_cnt_r == CNT_LAST) begin
            filt_data_r <= data_sync_r[1];
            data_cnt_r  <= '0;
        end else begin
            data_cnt_r <= data_cnt_r + CW'(1);
        end
    end

    assign filt_clk  = filt_clk_r;
    assign filt_data = filt_data_r;
    assign fall      = fall_r;

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host frame receiver with scan-code set 2 decode into
// make/break pulses, prefix handling, frame checks and repeat suppression.
module ps2_scancode_rx
    import ps2_scancode_rx_pkg::*;
#(
    parameter int FILTER_LEN      = 8,
    parameter int TIMEOUT_CYC     = 50000,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    ps2_scancode_rx_if.master bus
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    logic          filt_clk_s;
    logic          filt_data_s;
    logic          fall_s;
    logic          edge_s;

    ps2_state_e    state_r;
    logic [2:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          par_r;
    logic [TW-1:0] to_cnt_r;
    logic          byte_vld_r;
    logic          err_r;

    logic          brk_pend_r;
    logic          ext_pend_r;
    logic [8:0]    held_r;
    logic          new_key_r;
    logic          key_released_r;
    logic [7:0]    key_code_r;
    logic          key_extended_r;
    logic          held_match_s;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_line_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (bus.ps2_clk),
        .ps2_data  (bus.ps2_data),
        .filt_clk  (filt_clk_s),
        .filt_data (filt_data_s),
        .fall      (fall_s)
    );

    assign edge_s       = fall_s & ~filt_clk_s;
    assign held_match_s = (held_r != 9'h000) && (held_r == {ext_pend_r, shift_r});

    // Frame FSM with mid-frame timeout; closes a frame as valid byte or error
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            par_r      <= 1'b0;
            to_cnt_r   <= '0;
            byte_vld_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            byte_vld_r <= 1'b0;
            err_r      <= 1'b0;
            if (edge_s) begin
                to_cnt_r <= '0;
                case (state_r)
                    ST_IDLE: begin
                        if (!filt_data_s) begin
                            state_r   <= ST_DATA;
                            bit_cnt_r <= 3'd0;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        shift_r <= {filt_data_s, shift_r[7:1]};
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_PARITY;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end
                    ST_PARITY: begin
                        par_r   <= filt_data_s;
                        state_r <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_r <= ST_IDLE;
                        if (filt_data_s && odd_parity_ok(shift_r, par_r)) begin
                            byte_vld_r <= 1'b1;
                        end else begin
                            err_r <= 1'b1;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end else if (state_r != ST_IDLE) begin
                if (to_cnt_r == TO_LAST) begin
                    state_r  <= ST_IDLE;
                    err_r    <= 1'b1;
                    to_cnt_r <= '0;
                end else begin
                    to_cnt_r <= to_cnt_r + TW'(1);
                end
            end else begin
                to_cnt_r <= '0;
            end
        end
    end

    // Byte decode: prefixes, make/break events and held-code tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            brk_pend_r     <= 1'b0;
            ext_pend_r     <= 1'b0;
            held_r         <= 9'h000;
            new_key_r      <= 1'b0;
            key_released_r <= 1'b0;
            key_code_r     <= 8'h00;
            key_extended_r <= 1'b0;
        end else begin
            new_key_r      <= 1'b0;
            key_released_r <= 1'b0;
            if (err_r) begin
                brk_pend_r <= 1'b0;
                ext_pend_r <= 1'b0;
            end else if (byte_vld_r) begin
                case (shift_r)
                    PS2_BREAK: brk_pend_r <= 1'b1;
                    PS2_EXT:   ext_pend_r <= 1'b1;
                    default: begin
                        brk_pend_r <= 1'b0;
                        ext_pend_r <= 1'b0;
                        if (brk_pend_r) begin
                            key_released_r <= 1'b1;
                            key_code_r     <= shift_r;
                            key_extended_r <= ext_pend_r;
                            if (held_match_s) begin
                                held_r <= 9'h000;
                            end
                        end else if (SUPPRESS_REPEAT && held_match_s) begin
                            new_key_r <= 1'b0;
                        end else begin
                            new_key_r      <= 1'b1;
                            key_code_r     <= shift_r;
                            key_extended_r <= ext_pend_r;
                            held_r         <= {ext_pend_r, shift_r};
                        end
                    end
                endcase
            end else begin
                brk_pend_r <= brk_pend_r;
            end
        end
    end

    assign bus.new_key      = new_key_r;
    assign bus.key_released = key_released_r;
    assign bus.key_code     = key_code_r;
    assign bus.key_extended = key_extended_r;
    assign bus.frame_err    = err_r;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: directed PS/2 frames push expected
// events, a negedge monitor pops and compares every event the DUT emits.
module tb_ps2_scancode_rx;
    import ps2_scancode_rx_pkg::*;

    localparam int TIMEOUT_CYC = 400;
    localparam int HALF        = 40;
    localparam int IDLE_GAP    = 100;

    localparam logic [1:0] EV_MAKE = 2'd0;
    localparam logic [1:0] EV_BRK  = 2'd1;
    localparam logic [1:0] EV_ERR  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] code;
        logic       ext;
    } ev_t;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;
    ev_t  exp_q[$];

    ps2_scancode_rx_if u_if ();

    ps2_scancode_rx #(
        .FILTER_LEN      (8),
        .TIMEOUT_CYC     (TIMEOUT_CYC),
        .SUPPRESS_REPEAT (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input logic [1:0] kind, input logic [7:0] code, input logic ext);
        ev_t e;
        e.kind = kind;
        e.code = code;
        e.ext  = ext;
        exp_q.push_back(e);
    endtask

    // Sends the first nbits of a frame (start, data LSB first, parity, stop)
    task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] bits;
        logic        p;
        p = ~^b;
        if (bad_par) p = ~p;
        bits = {1'b1, p, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            u_if.ps2_data = bits[i];
            repeat (HALF) @(posedge clk);
            u_if.ps2_clk = 1'b0;
            repeat (HALF) @(posedge clk);
            u_if.ps2_clk = 1'b1;
        end
        u_if.ps2_data = 1'b1;
        repeat (IDLE_GAP) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    task automatic check_outputs_zero(input string tag);
        @(negedge clk);
        check({tag, ".new_key"},      {31'd0, u_if.new_key},      32'd0);
        check({tag, ".key_released"}, {31'd0, u_if.key_released}, 32'd0);
        check({tag, ".key_code"},     {24'd0, u_if.key_code},     32'd0);
        check({tag, ".key_extended"}, {31'd0, u_if.key_extended}, 32'd0);
        check({tag, ".frame_err"},    {31'd0, u_if.frame_err},    32'd0);
    endtask

    // Monitor: every output pulse must match the head of the expectation queue
    always @(negedge clk) begin
        if (!reset && (u_if.new_key || u_if.key_released || u_if.frame_err)) begin
            ev_t got;
            ev_t want;
            got.kind = u_if.frame_err ? EV_ERR : (u_if.key_released ? EV_BRK : EV_MAKE);
            got.code = u_if.frame_err ? 8'h00 : u_if.key_code;
            got.ext  = u_if.frame_err ? 1'b0  : u_if.key_extended;
            check("exclusive_pulse", {31'd0, u_if.new_key & u_if.key_released}, 32'd0);
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_event: got kind=%0d code=%02h ext=%0b expected none",
                         got.kind, got.code, got.ext);
            end else begin
                want = exp_q.pop_front();
                check("event", {21'd0, got}, {21'd0, want});
            end
        end
    end

    initial begin
        int budget;
        compared      = 0;
        mismatched    = 0;
        reset         = 1'b1;
        u_if.ps2_clk  = 1'b1;
        u_if.ps2_data = 1'b1;
        repeat (5) @(posedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (20) @(posedge clk);

        // Plain make
        expect_ev(EV_MAKE, KB_Z, 1'b0);
        send_byte(KB_Z);
        // Break clears the held code
        expect_ev(EV_BRK, KB_Z, 1'b0);
        send_byte(PS2_BREAK);
        send_byte(KB_Z);
        // Extended make then extended break
        expect_ev(EV_MAKE, KB_UP, 1'b1);
        send_byte(PS2_EXT);
        send_byte(KB_UP);
        expect_ev(EV_BRK, KB_UP, 1'b1);
        send_byte(PS2_EXT);
        send_byte(PS2_BREAK);
        send_byte(KB_UP);
        // Parity error, then a good byte; key_code holds across the error
        expect_ev(EV_ERR, 8'h00, 1'b0);
        send_bits(KB_Z, 1'b1, 11);
        @(negedge clk);
        check("held_code_after_err", {24'd0, u_if.key_code}, 32'h75);
        check("held_ext_after_err",  {31'd0, u_if.key_extended}, 32'd1);
        expect_ev(EV_MAKE, KB_X, 1'b0);
        send_byte(KB_X);
        // Mid-frame timeout, then recovery
        expect_ev(EV_ERR, 8'h00, 1'b0);
        send_bits(KB_Z, 1'b0, 5);
        repeat (TIMEOUT_CYC + 50) @(posedge clk);
        expect_ev(EV_MAKE, KB_Z, 1'b0);
        send_byte(KB_Z);
        // Release, then typematic repeats yield exactly one make
        expect_ev(EV_BRK, KB_Z, 1'b0);
        send_byte(PS2_BREAK);
        send_byte(KB_Z);
        expect_ev(EV_MAKE, KB_Z, 1'b0);
        send_byte(KB_Z);
        send_byte(KB_Z);
        send_byte(KB_Z);
        // Reset in the middle of a fourth repeat discards it and the held code
        send_bits(KB_Z, 1'b0, 6);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        check_outputs_zero("mid_reset");
        reset = 1'b0;
        repeat (50) @(posedge clk);
        expect_ev(EV_MAKE, KB_Z, 1'b0);
        send_byte(KB_Z);

        budget = 2000;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        check("pending_events", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
